note_sequencer: RTL

NOTE_SEQUENCER -- requirements
Module: note_sequencer

---
 rtl/music_pkg.sv | 14 +
 rtl/tempo_tick_gen.sv | 50 +++++
 rtl/note_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/music_pkg.sv
// Shared sequencer state encoding and musical timing constants for the
// note sequencer and its tempo tick generator.
package music_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY,
        DONE
    } seq_state_t;

    localparam int SECS_PER_MIN = 60;

endpackage

// File: rtl/tempo_tick_gen.sv
// Tempo tick generator: phase accumulator that converts a live BPM value into
// duration ticks with an exact long-run average and no divider.
module tempo_tick_gen
    import music_pkg::*;
#(
    parameter int CLOCK_FREQ     = 100_000_000,
    parameter int TICKS_PER_BEAT = 16,
    parameter int BPM_W          = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [BPM_W-1:0] i_bpm,
    output logic             o_tick
);

    localparam longint LIMIT   = longint'(CLOCK_FREQ) * longint'(SECS_PER_MIN);
    localparam longint MAX_INC = (longint'(1) << BPM_W) * longint'(TICKS_PER_BEAT);
    localparam int     ACC_W   = $clog2(LIMIT + MAX_INC);
    localparam logic [ACC_W:0] LIMIT_X = (ACC_W+1)'(LIMIT);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W:0]   w_inc;
    logic [ACC_W:0]   w_sum;
    logic             w_active;
    logic             w_wrap;

    // A zero tempo must neither tick nor disturb the stored phase.
    assign w_active = i_enable && (i_bpm != '0);
    assign w_inc    = (ACC_W+1)'(i_bpm) * (ACC_W+1)'(TICKS_PER_BEAT);
    assign w_sum    = {1'b0, r_acc} + w_inc;
    assign w_wrap   = (w_sum >= LIMIT_X);
    assign o_tick   = w_active && !i_clear && w_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (w_active) begin
            if (w_wrap) begin
                r_acc <= ACC_W'(w_sum - LIMIT_X);
            end else begin
                r_acc <= w_sum[ACC_W-1:0];
            end
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Note sequencer: walks an external duration ROM and gates notes at a live tempo.
// Define NOTE_SEQ_ARTIC_GAP_EN to silence the tail of each longer note.
module note_sequencer
    import music_pkg::*;
#(
    parameter int CLOCK_FREQ     = 100_000_000,
    parameter int INDEX_W        = 11,
    parameter int DUR_W          = 8,
    parameter int TICKS_PER_BEAT = 16,
    parameter int BPM_W          = 9,
    parameter int GAP_TICKS      = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic               loop_en,
    input  logic [BPM_W-1:0]   bpm,
    output logic [INDEX_W-1:0] note_index,
    input  logic [DUR_W-1:0]   note_dur,
    output logic               gate,
    output logic               note_start,
    output logic               busy,
    output logic               done
);

`ifdef NOTE_SEQ_ARTIC_GAP_EN
    localparam bit ARTIC_GAP_EN = 1'b1;
`else
    localparam bit ARTIC_GAP_EN = 1'b0;
`endif

    localparam logic [DUR_W-1:0]   GAP_LEN    = DUR_W'(GAP_TICKS);
    localparam logic [DUR_W-1:0]   DUR_ONE    = DUR_W'(1);
    localparam logic [INDEX_W-1:0] INDEX_LAST = '1;
    localparam logic [INDEX_W-1:0] INDEX_ONE  = INDEX_W'(1);

    seq_state_t         r_state;
    seq_state_t         w_nextState;
    logic [INDEX_W-1:0] r_index;
    logic [DUR_W-1:0]   r_cnt;
    logic [DUR_W-1:0]   r_dur;
    logic               r_gate;
    logic               r_noteStart;
    logic               r_eos;

    logic               w_tick;
    logic               w_clear;
    logic               w_lastTick;
    logic               w_songEnd;
    logic               w_rewind;
    logic               w_gapHit;

    assign w_clear = start && !stop;

    tempo_tick_gen #(
        .CLOCK_FREQ    (CLOCK_FREQ),
        .TICKS_PER_BEAT(TICKS_PER_BEAT),
        .BPM_W         (BPM_W)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_enable(!pause),
        .i_bpm   (bpm),
        .o_tick  (w_tick)
    );

    // r_eos marks running off the last ROM address, handled like a zero duration.
    assign w_lastTick = (r_state == PLAY) && w_tick && (r_cnt == DUR_ONE);
    assign w_songEnd  = (note_dur == '0) || r_eos;
    assign w_rewind   = w_songEnd && loop_en && (r_index != '0);
    assign w_gapHit   = ARTIC_GAP_EN && (r_cnt <= GAP_LEN) && (r_dur > GAP_LEN);

    assign note_index = r_index;
    assign gate       = r_gate;
    assign note_start = r_noteStart;
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE) && !pause && !stop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (stop) begin
            w_nextState = IDLE;
        end else if (start) begin
            w_nextState = LOAD;
        end else if (!pause) begin
            case (r_state)
                IDLE:    w_nextState = IDLE;
                LOAD: begin
                    if (!w_songEnd) begin
                        w_nextState = PLAY;
                    end else if (w_rewind) begin
                        w_nextState = LOAD;
                    end else begin
                        w_nextState = DONE;
                    end
                end
                PLAY: begin
                    if (w_lastTick) begin
                        w_nextState = LOAD;
                    end
                end
                DONE:    w_nextState = IDLE;
                default: w_nextState = IDLE;
            endcase
        end
    end

    // Gate stays up through the one-cycle LOAD between notes so back-to-back notes are legato.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_index     <= '0;
            r_cnt       <= '0;
            r_dur       <= '0;
            r_gate      <= 1'b0;
            r_noteStart <= 1'b0;
            r_eos       <= 1'b0;
        end else begin
            r_noteStart <= 1'b0;
            if (stop || start) begin
                r_index <= '0;
                r_gate  <= 1'b0;
                r_eos   <= 1'b0;
            end else if (!pause) begin
                case (r_state)
                    LOAD: begin
                        r_eos <= 1'b0;
                        if (!w_songEnd) begin
                            r_cnt       <= note_dur;
                            r_dur       <= note_dur;
                            r_gate      <= 1'b1;
                            r_noteStart <= 1'b1;
                        end else begin
                            r_gate <= 1'b0;
                            if (w_rewind) begin
                                r_index <= '0;
                            end
                        end
                    end
                    PLAY: begin
                        r_gate <= !w_gapHit;
                        if (w_tick) begin
                            r_cnt <= r_cnt - DUR_ONE;
                            if (r_cnt == DUR_ONE) begin
                                if (r_index == INDEX_LAST) begin
                                    r_eos <= 1'b1;
                                end else begin
                                    r_index <= r_index + INDEX_ONE;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
